// File: rtl/dec_exe_pipe_reg.sv
// dec_exe_pipe_reg: Decode->Execute pipeline register with stall, flush, valid and event counters
module dec_exe_pipe_reg #(
  parameter int DATA_W              = 32,
  parameter int NUM_DATA            = 5,
  parameter int CTRL_W              = 16,
  parameter int RD_W                = 5,
  parameter int CNT_W               = 16,
  parameter int CLEAR_DATA_ON_FLUSH = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       StallE,
  input  logic                       FlushE,
  input  logic                       ValidD,
  input  logic [CTRL_W-1:0]          CtrlD,
  input  logic [NUM_DATA*DATA_W-1:0] DataD,
  input  logic [RD_W-1:0]            RdD,
  input  logic                       CntClr,
  output logic                       ValidE,
  output logic [CTRL_W-1:0]          CtrlE,
  output logic [NUM_DATA*DATA_W-1:0] DataE,
  output logic [RD_W-1:0]            RdE,
  output logic [CNT_W-1:0]           StallCount,
  output logic [CNT_W-1:0]           FlushCount
);
  localparam bit CLR_DATA = (CLEAR_DATA_ON_FLUSH != 0);
  logic                       valid_q, valid_d;
  logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
  logic [NUM_DATA*DATA_W-1:0] data_q, data_d;
  logic [RD_W-1:0]            rd_q, rd_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;
  logic                       hold;
  logic                       stall_ev;
  assign hold     = FlushE | StallE;
  assign stall_ev = StallE & ~FlushE;
  // Next state: flush beats stall beats load; control is zeroed whenever the slot is a bubble
  always_comb begin
    valid_d     = FlushE ? 1'b0 : StallE ? valid_q : ValidD;
    ctrl_d      = FlushE ? '0 : StallE ? ctrl_q : (ValidD ? CtrlD : '0);
    data_d      = (FlushE && CLR_DATA) ? '0 : hold ? data_q : DataD;
    rd_d        = (FlushE && CLR_DATA) ? '0 : hold ? rd_q : RdD;
    stall_cnt_d = CntClr ? '0 : (stall_ev && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = CntClr ? '0 : (FlushE && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // Stage and counter registers, cleared asynchronously by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign ValidE     = valid_q;
  assign CtrlE      = ctrl_q;
  assign DataE      = data_q;
  assign RdE        = rd_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_dec_exe_pipe_reg.sv
// tb_dec_exe_pipe_reg: table, directed and random checks of dec_exe_pipe_reg in three configurations
module tb_dec_exe_pipe_reg;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0, flush = 1'b0, validd = 1'b0, cntclr = 1'b0;
  logic [15:0]  ctrl = '0;
  logic [159:0] data = '0;
  logic [4:0]   rd = '0;
  logic         ve [3];
  logic [15:0]  ce [3];
  logic [159:0] de [3];
  logic [4:0]   re [3];
  logic [15:0]  sc [3];
  logic [15:0]  fc [3];
  logic [3:0]   sc2, fc2;
  int total = 0, bad = 0;
  logic         m_v [3];
  logic [15:0]  m_c [3];
  logic [159:0] m_d [3];
  logic [4:0]   m_r [3];
  int           m_sc [3], m_fc [3];
  int           mx [3] = '{65535, 65535, 15};
  always #5 clk = ~clk;
  dec_exe_pipe_reg dut0 (
    .CLK(clk), .RST_N(rst_n), .StallE(stall), .FlushE(flush), .ValidD(validd), .CtrlD(ctrl),
    .DataD(data), .RdD(rd), .CntClr(cntclr), .ValidE(ve[0]), .CtrlE(ce[0]), .DataE(de[0]),
    .RdE(re[0]), .StallCount(sc[0]), .FlushCount(fc[0]));
  dec_exe_pipe_reg #(.CLEAR_DATA_ON_FLUSH(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .StallE(stall), .FlushE(flush), .ValidD(validd), .CtrlD(ctrl),
    .DataD(data), .RdD(rd), .CntClr(cntclr), .ValidE(ve[1]), .CtrlE(ce[1]), .DataE(de[1]),
    .RdE(re[1]), .StallCount(sc[1]), .FlushCount(fc[1]));
  dec_exe_pipe_reg #(.CNT_W(4)) dut2 (
    .CLK(clk), .RST_N(rst_n), .StallE(stall), .FlushE(flush), .ValidD(validd), .CtrlD(ctrl),
    .DataD(data), .RdD(rd), .CntClr(cntclr), .ValidE(ve[2]), .CtrlE(ce[2]), .DataE(de[2]),
    .RdE(re[2]), .StallCount(sc2), .FlushCount(fc2));
  assign sc[2] = {12'b0, sc2};
  assign fc[2] = {12'b0, fc2};
  typedef struct {
    logic        st, fl, vd, clr;
    logic [15:0] c;
    logic [31:0] w;
    logic [4:0]  r;
    logic        ev;
    logic [15:0] ec;
    logic [31:0] ew;
    logic [4:0]  er;
    int          esc, efc;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_zero();
    for (int i = 0; i < 3; i++) begin
      m_v[i] = 1'b0; m_c[i] = '0; m_d[i] = '0; m_r[i] = '0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask
  task automatic model_edge();
    if (!rst_n) begin
      model_zero();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (cntclr) begin
        m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (stall && !flush) m_sc[i] = (m_sc[i] + 1 > mx[i]) ? mx[i] : m_sc[i] + 1;
        if (flush) m_fc[i] = (m_fc[i] + 1 > mx[i]) ? mx[i] : m_fc[i] + 1;
      end
      if (flush) begin
        m_v[i] = 1'b0; m_c[i] = '0;
        if (i == 1) begin m_d[i] = '0; m_r[i] = '0; end
      end else if (!stall) begin
        m_v[i] = validd; m_c[i] = validd ? ctrl : 16'h0; m_d[i] = data; m_r[i] = rd;
      end
    end
  endtask
  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), 160'(ve[i]), 160'(m_v[i]));
      chk($sformatf("%s.ctrl%0d", tag, i), 160'(ce[i]), 160'(m_c[i]));
      chk($sformatf("%s.data%0d", tag, i), de[i], m_d[i]);
      chk($sformatf("%s.rd%0d", tag, i), 160'(re[i]), 160'(m_r[i]));
      chk($sformatf("%s.scnt%0d", tag, i), 160'(sc[i]), 160'(m_sc[i]));
      chk($sformatf("%s.fcnt%0d", tag, i), 160'(fc[i]), 160'(m_fc[i]));
      if (!ve[i]) chk($sformatf("%s.bubble_ctrl%0d", tag, i), 160'(ce[i]), 160'(0));
    end
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic drive(input logic st, fl, vd, clr, input logic [15:0] c, input logic [31:0] w, input logic [4:0] r);
    stall = st; flush = fl; validd = vd; cntclr = clr; ctrl = c; data = {128'h0, w}; rd = r;
  endtask
  initial begin
    tbl[0]  = '{1'b0,1'b0,1'b1,1'b0,16'hBEEF,32'h1234_5678,5'd7, 1'b1,16'hBEEF,32'h1234_5678,5'd7, 0,0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,16'h0001,32'h0,5'd1,         1'b1,16'hBEEF,32'h1234_5678,5'd7, 1,0};
    tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,16'h0001,32'h0,5'd1,         1'b1,16'hBEEF,32'h1234_5678,5'd7, 2,0};
    tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,16'h0001,32'h0,5'd1,         1'b1,16'hBEEF,32'h1234_5678,5'd7, 3,0};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,16'h0001,32'h0,5'd1,         1'b0,16'h0,32'h1234_5678,5'd7,    3,1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,16'hFFFF,32'hAAAA_5555,5'd3, 1'b0,16'h0,32'hAAAA_5555,5'd3,    3,1};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,16'h1234,32'h1,5'd9,         1'b1,16'h1234,32'h1,5'd9,         3,1};
    tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,16'hFFFF,32'h2,5'd4,         1'b0,16'h0,32'h1,5'd9,            3,2};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,16'h0042,32'h3,5'd5,         1'b1,16'h0042,32'h3,5'd5,         0,0};
    tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,16'h0007,32'h4,5'd6,         1'b1,16'h0042,32'h3,5'd5,         0,0};
    tbl[10] = '{1'b1,1'b0,1'b1,1'b0,16'h0007,32'h4,5'd6,         1'b1,16'h0042,32'h3,5'd5,         1,0};
    model_zero();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 32'h1234_5678, 5'd7);
    repeat (2) step("in_reset");
    chk("reset_valid", 160'(ve[0]), 160'(0));
    chk("reset_data", de[0], 160'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].vd, tbl[i].clr, tbl[i].c, tbl[i].w, tbl[i].r);
      step($sformatf("row%0d", i));
      chk($sformatf("row%0d.valid", i), 160'(ve[0]), 160'(tbl[i].ev));
      chk($sformatf("row%0d.ctrl", i), 160'(ce[0]), 160'(tbl[i].ec));
      chk($sformatf("row%0d.word0", i), 160'(de[0][31:0]), 160'(tbl[i].ew));
      chk($sformatf("row%0d.rd", i), 160'(re[0]), 160'(tbl[i].er));
      chk($sformatf("row%0d.scnt", i), 160'(sc[0]), 160'(tbl[i].esc));
      chk($sformatf("row%0d.fcnt", i), 160'(fc[0]), 160'(tbl[i].efc));
      if (i == 4) begin
        chk("flush_clr.word0", 160'(de[1][31:0]), 160'(0));
        chk("flush_clr.rd", 160'(re[1]), 160'(0));
        chk("flush_clr.fcnt", 160'(fc[1]), 160'(1));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 32'h1234_5678, 5'd7);
    step("pre_rst_load");
    #3;
    rst_n = 1'b0;
    #1;
    model_zero();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst.valid%0d", i), 160'(ve[i]), 160'(0));
      chk($sformatf("async_rst.ctrl%0d", i), 160'(ce[i]), 160'(0));
      chk($sformatf("async_rst.data%0d", i), de[i], 160'(0));
      chk($sformatf("async_rst.rd%0d", i), 160'(re[i]), 160'(0));
    end
    step("rst_held");
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) step("sat_stall");
    chk("sat.scnt4", 160'(sc[2]), 160'(15));
    chk("sat.scnt16", 160'(sc[0]), 160'(20));
    cntclr = 1'b1;
    step("sat_clr");
    chk("sat_clr.scnt4", 160'(sc[2]), 160'(0));
    cntclr = 1'b0;
    step("sat_after");
    chk("sat_after.scnt4", 160'(sc[2]), 160'(1));
    stall = 1'b0; flush = 1'b1;
    for (int i = 0; i < 18; i++) step("sat_flush");
    chk("sat.fcnt4", 160'(fc[2]), 160'(15));
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      validd = $urandom_range(0, 1);
      cntclr = ($urandom_range(0, 31) == 0);
      ctrl = 16'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rd = 5'($urandom);
      step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dec_exe_pipe_reg.md
Name: dec_exe_pipe_reg

Overview:
Parametrised Decode→Execute pipeline register, successor to the fixed-field ID/EX register. Carries a generic control bundle, NUM_DATA data words and a destination register index from Decode into Execute. Adds what the fixed version lacks:
- asynchronous active-low reset
- stall (hold)
- flush (bubble insertion)
- a per-stage valid bit
- saturating stall and flush event counters, readable by the hazard unit and debug logic

Parameters:
DATA_W, 32, width of each data word (RD1, RD2, PC, ImmExt, PCPlus4, ...)
NUM_DATA, 5, number of data words carried
CTRL_W, 16, width of packed control bundle (RegWrite, ResultSrc, MemWrite, Jump, Type, Branch, ALUControl, ALUSrc, JumpReg, funct3 bits, ...)
RD_W, 5, destination register index width
CNT_W, 16, width of each event counter
CLEAR_DATA_ON_FLUSH, 0, 1 = data words and RdE zeroed on flush; 0 = data and RdE hold on flush

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
StallE  input  1  hold all stage contents this cycle
FlushE  input  1  insert bubble this cycle
ValidD  input  1  Decode holds a real instruction
CtrlD  input  CTRL_W  control bundle from Decode
DataD  input  NUM_DATA*DATA_W  packed data words; word k at bits [k*DATA_W +: DATA_W]
RdD  input  RD_W  destination register index from Decode
CntClr  input  1  synchronous clear of both counters
ValidE  output  1  Execute holds a real instruction
CtrlE  output  CTRL_W  registered control bundle, gated by valid
DataE  output  NUM_DATA*DATA_W  registered data words
RdE  output  RD_W  registered destination index
StallCount  output  CNT_W  saturating count of stall cycles
FlushCount  output  CNT_W  saturating count of flush cycles

Behaviour:
Reset:
- RST_N low asynchronously forces ValidE=0, CtrlE=0, DataE=0, RdE=0, StallCount=0, FlushCount=0.
- Release is synchronous to the next CLK edge. No capture occurs on the edge where RST_N is still low.
- Reset mid-stall or mid-flush discards all state.

Per-edge priority (RST_N high): FlushE > StallE > load.
- Flush: ValidE←0, CtrlE←0.
  - CLEAR_DATA_ON_FLUSH=1: DataE←0, RdE←0.
  - CLEAR_DATA_ON_FLUSH=0: DataE and RdE hold.
- Stall (FlushE=0): all stage registers hold their values.
- Load (FlushE=0, StallE=0): ValidE←ValidD, CtrlE←(ValidD ? CtrlD : 0), DataE←DataD, RdE←RdD.

Timing and invariants:
- Latency is one cycle. No combinational path from any input to any output.
- Invariant: ValidE=0 ⇒ CtrlE=0. A bubble must never assert RegWrite, MemWrite, Branch or Jump downstream.

Counters:
- StallCount increments on an edge with StallE=1, FlushE=0.
- FlushCount increments on an edge with FlushE=1, independent of StallE.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- CntClr=1 zeroes both on the edge. CntClr beats an increment in the same cycle.
- Counters are unaffected by ValidD.

Simultaneous StallE=1 and FlushE=1: bubble inserted, FlushCount increments, StallCount does not.

Test Plan:
- Reset mid-stream: load CtrlD=16'hBEEF, ValidD=1, DataD word0=32'h1234_5678, RdD=5'd7. Pulse RST_N low between edges → all outputs 0 immediately, before the next CLK edge.
- Normal load then hold: load as above, then StallE=1 for 3 cycles with CtrlD=16'h0001 → CtrlE stays 16'hBEEF, RdE stays 7, StallCount=3.
- Flush, both parameter settings: FlushE=1 after the load.
  - CLEAR_DATA_ON_FLUSH=0: ValidE=0, CtrlE=0, word0 stays 32'h1234_5678, RdE=7.
  - CLEAR_DATA_ON_FLUSH=1: word0=0, RdE=0.
  - Both: FlushCount=1.
- Stall+flush together for 1 cycle → ValidE=0, CtrlE=0, FlushCount increments, StallCount unchanged.
- Invalid load: ValidD=0, CtrlD=16'hFFFF → ValidE=0, CtrlE=0, DataE=DataD.
- Counter saturation and clear: CNT_W=4, stall 20 cycles → StallCount=15. Then CntClr=1 with StallE=1 → StallCount=0, and the next stalled edge gives 1.
